bcd_split_scheduler: RTL and testbench

//  Time-shares one iterative divide-by-10 unit among N_CH binary counters.

---
 rtl/bcd_split_scheduler.sv | 175 +++++++++++++++++
 tb/tb_bcd_split_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_split_scheduler.sv
// Round-robin binary-to-BCD splitter: one restoring divide-by-10 unit shared by N_CH counters.
// Optional SKIP_UNCHANGED_EN: channels whose value has not changed since their last store are skipped.
module bcd_split_scheduler #(
    parameter int N_CH = 2,
    parameter int W    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH*W-1:0]     val_flat,
    output logic [N_CH*(W-3)-1:0] dec_flat,
    output logic [N_CH*4-1:0]     unit_flat,
    output logic [N_CH-1:0]       valid,
    output logic [N_CH-1:0]       ovf,
    output logic                  busy,
    output logic [2:0]            cur_ch
);
    localparam int QW = W - 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DIV   = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(W - 1);
    localparam logic [2:0] PTR_LAST = 3'(N_CH - 1);

    logic [1:0]   state_reg;
    logic [2:0]   ptr_reg;
    logic [2:0]   cur_ch_reg;
    logic [3:0]   cnt_reg;
    logic [W-1:0] dvd_reg;
    logic [3:0]   rem_reg;
    logic [W-1:0] quo_reg;

    logic [W-1:0]  val_arr [N_CH];
    logic [QW-1:0] dec_reg [N_CH];
    logic [3:0]    unit_reg [N_CH];
    logic          valid_reg [N_CH];
    logic          ovf_reg [N_CH];

    logic [W-1:0] cur_val;
    logic         cur_valid;
    logic [2:0]   ptr_next;
    logic [4:0]   partial;
    logic         ge;
    logic [3:0]   rem_next;
    logic         skip;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign val_arr[gi]                = val_flat[gi*W +: W];
            assign dec_flat[gi*QW +: QW]      = dec_reg[gi];
            assign unit_flat[gi*4 +: 4]       = unit_reg[gi];
            assign valid[gi]                  = valid_reg[gi];
            assign ovf[gi]                    = ovf_reg[gi];

            // Digit pair, valid and ovf update together so the display never sees a torn pair.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dec_reg[gi]   <= '0;
                    unit_reg[gi]  <= '0;
                    valid_reg[gi] <= 1'b0;
                    ovf_reg[gi]   <= 1'b0;
                end else if (state_reg == S_STORE && cur_ch_reg == 3'(gi)) begin
                    dec_reg[gi]   <= quo_reg[QW-1:0];
                    unit_reg[gi]  <= rem_reg;
                    valid_reg[gi] <= 1'b1;
                    ovf_reg[gi]   <= (quo_reg >= W'(10));
                end
            end
        end
    endgenerate

    always_comb begin
        cur_val   = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ptr_reg == 3'(i)) begin
                cur_val   = val_arr[i];
                cur_valid = valid_reg[i];
            end
        end
    end

    assign ptr_next = (ptr_reg == PTR_LAST) ? 3'd0 : ptr_reg + 3'd1;
    assign partial  = {rem_reg, dvd_reg[W-1]};
    assign ge       = (partial >= 5'd10);
    assign rem_next = ge ? 4'(partial - 5'd10) : partial[3:0];

`ifdef SKIP_UNCHANGED_EN
    logic [W-1:0] last_val_reg [N_CH];
    logic [W-1:0] snap_reg;
    logic [W-1:0] cur_last;

    always_comb begin
        cur_last = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ptr_reg == 3'(i)) cur_last = last_val_reg[i];
        end
    end

    assign skip = (state_reg == S_LOAD) && cur_valid && (cur_val == cur_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_reg <= '0;
        end else if (state_reg == S_LOAD) begin
            snap_reg <= cur_val;
        end
    end

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    last_val_reg[gi] <= '0;
                end else if (state_reg == S_STORE && cur_ch_reg == 3'(gi)) begin
                    last_val_reg[gi] <= snap_reg;
                end
            end
        end
    endgenerate
`else
    logic unused_valid;
    assign unused_valid = cur_valid;
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= 3'd0;
            cur_ch_reg <= 3'd0;
            cnt_reg    <= 4'd0;
            dvd_reg    <= '0;
            rem_reg    <= 4'd0;
            quo_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (en) state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    cur_ch_reg <= ptr_reg;
                    if (skip) begin
                        ptr_reg <= ptr_next;
                    end else begin
                        dvd_reg   <= cur_val;
                        rem_reg   <= 4'd0;
                        quo_reg   <= '0;
                        cnt_reg   <= 4'd0;
                        state_reg <= S_DIV;
                    end
                end
                S_DIV: begin
                    dvd_reg <= dvd_reg << 1;
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[W-2:0], ge};
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == CNT_LAST) state_reg <= S_STORE;
                end
                default: begin
                    ptr_reg   <= ptr_next;
                    state_reg <= en ? S_LOAD : S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg != S_IDLE) && !skip;
    assign cur_ch = cur_ch_reg;

endmodule

// File: tb/tb_bcd_split_scheduler.sv
// Directed bench for bcd_split_scheduler (N_CH=2, W=7): vector table plus multi-cycle sequences.
module tb_bcd_split_scheduler;
    localparam int N_CH = 2;
    localparam int W    = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [13:0] val_flat;
    logic [7:0]  dec_flat;
    logic [7:0]  unit_flat;
    logic [1:0]  valid;
    logic [1:0]  ovf;
    logic        busy;
    logic [2:0]  cur_ch;

    int checks = 0;
    int errors = 0;

    bcd_split_scheduler #(.N_CH(N_CH), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .val_flat(val_flat),
        .dec_flat(dec_flat), .unit_flat(unit_flat), .valid(valid),
        .ovf(ovf), .busy(busy), .cur_ch(cur_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v0, v1;
        int d0, u0, o0;
        int d1, u1, o1;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        check("reset_outputs", {dec_flat, unit_flat, valid, ovf, busy, cur_ch}, 32'd0);
        rst = 1'b0;
    endtask

    // Advances until valid bit ch is set; returns edges taken, or -1 on timeout.
    task automatic wait_valid(input int ch, output int cycles);
        cycles = 0;
        while (valid[ch] !== 1'b1 && cycles < 100) begin
            step(1);
            cycles++;
        end
        if (valid[ch] !== 1'b1) cycles = -1;
    endtask

    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (busy !== 1'b1 && cycles < 20) begin
            step(1);
            cycles++;
        end
        if (busy !== 1'b1) cycles = -1;
    endtask

    initial begin
        int c;
        int bad;
        logic [19:0] snap;

        rst = 1'b1;
        en = 1'b0;
        val_flat = '0;

        vecs[0] = '{v0: 37, v1: 5,   d0: 3,  u0: 7, o0: 0, d1: 0,  u1: 5, o1: 0};
        vecs[1] = '{v0: 0,  v1: 127, d0: 0,  u0: 0, o0: 0, d1: 12, u1: 7, o1: 1};
        vecs[2] = '{v0: 99, v1: 100, d0: 9,  u0: 9, o0: 0, d1: 10, u1: 0, o1: 1};
        vecs[3] = '{v0: 10, v1: 9,   d0: 1,  u0: 0, o0: 0, d1: 0,  u1: 9, o1: 0};
        vecs[4] = '{v0: 64, v1: 42,  d0: 6,  u0: 4, o0: 0, d1: 4,  u1: 2, o1: 0};

        for (int i = 0; i < 5; i++) begin
            val_flat = {7'(vecs[i].v1), 7'(vecs[i].v0)};
            en = 1'b1;
            do_reset();
            wait_valid(1, c);
            check("sweep_timeout", (c < 0) ? 1 : 0, 0);
            check("valid_both", valid, 2'b11);
            check("dec0", dec_flat[3:0], vecs[i].d0);
            check("unit0", unit_flat[3:0], vecs[i].u0);
            check("ovf0", ovf[0], vecs[i].o0);
            check("dec1", dec_flat[7:4], vecs[i].d1);
            check("unit1", unit_flat[7:4], vecs[i].u1);
            check("ovf1", ovf[1], vecs[i].o1);
            $display("vec %0d: ch0=%0d -> %0d/%0d ovf=%0d, ch1=%0d -> %0d/%0d ovf=%0d",
                     i, vecs[i].v0, dec_flat[3:0], unit_flat[3:0], ovf[0],
                     vecs[i].v1, dec_flat[7:4], unit_flat[7:4], ovf[1]);
        end

        // Latency: LOAD to stored outputs is W+2 edges, and the second channel follows W+2 later.
        val_flat = {7'd5, 7'd37};
        en = 1'b1;
        do_reset();
        wait_busy(c);
        check("busy_after_reset", (c < 0) ? 0 : 1, 1);
        wait_valid(0, c);
        check("latency_ch0", c, W + 2);
        check("valid_ch0_only", valid, 2'b01);
        wait_valid(1, c);
        check("latency_ch1", c, W + 2);
        $display("latency: ch0/ch1 each %0d cycles after LOAD", W + 2);

        // Input change after LOAD does not affect the conversion in flight.
        do_reset();
        wait_busy(c);
        step(1);
        val_flat[6:0] = 7'd64;
        wait_valid(0, c);
        check("snapshot_dec0", dec_flat[3:0], 3);
        check("snapshot_unit0", unit_flat[3:0], 7);
        c = 0;
        while (dec_flat[3:0] == 4'd3 && c < 40) begin
            step(1);
            c++;
        end
        check("resweep_dec0", dec_flat[3:0], 6);
        check("resweep_unit0", unit_flat[3:0], 4);
        $display("snapshot: first store 3/7, next sweep %0d/%0d", dec_flat[3:0], unit_flat[3:0]);

        // en falls mid-DIV: the store completes, then idle and stable, then resume at ch1.
        val_flat = {7'd5, 7'd37};
        do_reset();
        wait_busy(c);
        step(3);
        en = 1'b0;
        wait_valid(0, c);
        check("endrop_dec0", dec_flat[3:0], 3);
        check("endrop_unit0", unit_flat[3:0], 7);
        check("endrop_busy", busy, 0);
        snap = {dec_flat, unit_flat, valid, ovf};
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (busy !== 1'b0 || {dec_flat, unit_flat, valid, ovf} !== snap) bad++;
        end
        check("idle_stable", bad, 0);
        en = 1'b1;
        wait_valid(1, c);
        check("resume_cur_ch", cur_ch, 1);
        check("resume_unit1", unit_flat[7:4], 5);
        check("resume_valid0", valid[0], 1);
        $display("en drop: store completed, idle 50 cycles, resumed at ch%0d", cur_ch);

        // Reset during DIV of ch1 aborts it; conversion restarts from ch0.
        do_reset();
        wait_valid(0, c);
        step(3);
        rst = 1'b1;
        step(1);
        check("abort_outputs", {dec_flat, unit_flat, valid, ovf, busy, cur_ch}, 32'd0);
        rst = 1'b0;
        wait_valid(0, c);
        check("restart_valid", valid, 2'b01);
        check("restart_cur_ch", cur_ch, 0);
        check("restart_unit0", unit_flat[3:0], 7);
        $display("reset in DIV: outputs cleared, restarted at ch%0d", cur_ch);

`ifdef SKIP_UNCHANGED_EN
        val_flat = {7'd30, 7'd20};
        do_reset();
        wait_valid(1, c);
        step(1);
        snap = {dec_flat, unit_flat, valid, ovf};
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (busy !== 1'b0 || {dec_flat, unit_flat, valid, ovf} !== snap) bad++;
        end
        check("skip_quiet", bad, 0);
        val_flat[13:7] = 7'd42;
        c = 0;
        while (dec_flat[7:4] != 4'd4 && c < 40) begin
            step(1);
            c++;
        end
        check("skip_wake_time", (c <= 2 + W + 2) ? 1 : 0, 1);
        check("skip_dec1", dec_flat[7:4], 4);
        check("skip_unit1", unit_flat[7:4], 2);
        $display("skip: quiet while unchanged, ch1=42 converted after %0d cycles", c);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
